// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receiver: FSM state encoding and
// oversampling positions within one bit period.
package serial_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] MID_SAMPLE  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(15);

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    START     = 6'b000010,
    DATA      = 6'b000100,
    PARITY    = 6'b001000,
    STOP      = 6'b010000,
    WAIT_IDLE = 6'b100000
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  push,
  input  logic [7:0]            din,
  output logic                  full,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head entry is read straight from storage, so it holds its last value when empty.
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// 16x-oversampled UART receiver (8N1, or 8E1 when SERIAL_RX_PARITY_EN is defined)
// feeding an elastic byte FIFO that honours the consumer's ready.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DIV        = 156,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                rx_meta;
  logic                rx_s;
  logic [TW-1:0]       tcnt;
  logic                tick;
  rx_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          bitn;
  logic [7:0]          shreg;
  logic                par_ok;
  logic                stop_tick;
  logic                push_req;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TICK_ONE;
  end

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitn   <= '0;
      shreg  <= '0;
      par_ok <= 1'b1;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // A start bit that is already high again at mid-bit is a glitch.
          if (cnt == MID_SAMPLE) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              bitn  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == LAST_SAMPLE) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= '0;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7)
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST_SAMPLE) begin
            par_ok <= ~(^shreg ^ rx_s);
            cnt    <= '0;
            state  <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST_SAMPLE) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit verdicts are decoded in the sample cycle itself so push and pulses line up with it.
  assign stop_tick   = tick && (state == STOP) && (cnt == LAST_SAMPLE);
  assign push_req    = stop_tick && rx_s && par_ok;
  assign framing_err = stop_tick && !rx_s;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err  = stop_tick && rx_s && !par_ok;
`else
  assign parity_err  = 1'b0;
`endif

  assign pop     = ready && !fifo_empty;
  assign valid   = (fifo_count != '0);
  assign overrun = push_req && fifo_full && !pop;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push_req),
    .din   (shreg),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
